// File: rtl/div_sched.sv
// Round-robin scheduler sharing one iterative divider engine among several requesters.
// Launches one op at a time, holds the result until claimed, and drains flushed in-flight ops.
module div_sched #(
  parameter int unsigned nreq = 4,
  parameter int unsigned opw  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [nreq-1:0]           req_valid,
  output logic [nreq-1:0]           req_ready,
  input  logic [nreq*opw-1:0]       req_opid,
  input  logic [nreq*3-1:0]         req_funct,
  input  logic [nreq*64-1:0]        req_a,
  input  logic [nreq*64-1:0]        req_b,
  output logic                      div_start,
  output logic [2:0]                div_funct,
  output logic [63:0]               div_a,
  output logic [63:0]               div_b,
  input  logic                      div_done,
  input  logic [63:0]               div_result,
  output logic                      resp_valid,
  output logic [$clog2(nreq)-1:0]   resp_src,
  output logic [opw-1:0]            resp_opid,
  output logic [63:0]               resp_value,
  input  logic                      resp_claim,
  output logic [31:0]               ops_done
);

  localparam int unsigned SrcW = $clog2(nreq);

  typedef enum logic [1:0] {StIdle, StBusy, StResp, StDrain} state_e;

  state_e          state_q, state_d;
  logic [SrcW-1:0] rr_ptr_q, rr_ptr_d;
  logic [SrcW-1:0] src_q, src_d;
  logic [opw-1:0]  opid_q, opid_d;
  logic [2:0]      funct_q, funct_d;
  logic [63:0]     a_q, a_d, b_q, b_d;
  logic [63:0]     result_q, result_d;
  logic            start_q, start_d;
  logic [31:0]     ops_done_q, ops_done_d;

  logic [opw-1:0]  opid_arr  [nreq];
  logic [2:0]      funct_arr [nreq];
  logic [63:0]     a_arr     [nreq];
  logic [63:0]     b_arr     [nreq];

  logic [nreq-1:0] hi_mask, req_hi;
  logic            grant_vld;
  logic [SrcW-1:0] grant_idx;
  logic            accept;

  always_comb begin
    for (int i = 0; i < int'(nreq); i++) begin
      opid_arr[i]  = req_opid[i*opw +: opw];
      funct_arr[i] = req_funct[i*3 +: 3];
      a_arr[i]     = req_a[i*64 +: 64];
      b_arr[i]     = req_b[i*64 +: 64];
    end
  end

  // Prefer the lowest requester at or above rr_ptr; otherwise wrap to the lowest overall.
  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < int'(nreq); i++) begin
      hi_mask[i] = (i >= int'(rr_ptr_q));
    end
    req_hi    = req_valid & hi_mask;
    grant_vld = |req_valid;
    grant_idx = '0;
    for (int i = int'(nreq) - 1; i >= 0; i--) begin
      if (req_valid[i]) grant_idx = SrcW'(i);
    end
    if (|req_hi) begin
      for (int i = int'(nreq) - 1; i >= 0; i--) begin
        if (req_hi[i]) grant_idx = SrcW'(i);
      end
    end
  end

  assign accept = rst && (state_q == StIdle) && !flush && grant_vld;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    src_d      = src_q;
    opid_d     = opid_q;
    funct_d    = funct_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    start_d    = 1'b0;
    ops_done_d = ops_done_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          src_d    = grant_idx;
          opid_d   = opid_arr[grant_idx];
          funct_d  = funct_arr[grant_idx];
          a_d      = a_arr[grant_idx];
          b_d      = b_arr[grant_idx];
          rr_ptr_d = (32'(grant_idx) == nreq - 1) ? '0 : grant_idx + SrcW'(1);
          start_d  = 1'b1;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (flush) begin
          // A done in the flush cycle means nothing is left to drain.
          state_d = div_done ? StIdle : StDrain;
        end else if (div_done) begin
          result_d = div_result;
          state_d  = StResp;
        end
      end
      StResp: begin
        if (flush) begin
          state_d = StIdle;
        end else if (resp_claim) begin
          ops_done_d = ops_done_q + 32'd1;
          state_d    = StIdle;
        end
      end
      StDrain: begin
        if (div_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      src_q      <= '0;
      opid_q     <= '0;
      funct_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      start_q    <= 1'b0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      src_q      <= src_d;
      opid_q     <= opid_d;
      funct_q    <= funct_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      start_q    <= start_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign div_start  = start_q;
  assign div_funct  = funct_q;
  assign div_a      = a_q;
  assign div_b      = b_q;
  assign resp_valid = (state_q == StResp);
  assign resp_src   = src_q;
  assign resp_opid  = opid_q;
  assign resp_value = result_q;
  assign ops_done   = ops_done_q;

endmodule
